// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the multicycle RV32I control path: opcodes, FSM states
// and the datapath select encodings driven by the controller.
package riscv_ctrl_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JALR     = 4'd10,
      S_JAL      = 4'd11,
      S_LUI      = 4'd12,
      S_AUIPC    = 4'd13,
      S_TRAP     = 4'd14
   } state_t;

   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_RDATA  = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_BRANCH = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

   // Registered Moore part of the control word; fetch marks the FETCH state.
   typedef struct packed {
      logic       fetch;
      logic       pc_update;
      logic       branch;
      logic       adr_src;
      logic       mem_write;
      logic       reg_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       instr_done;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/multicycle_imm_decode.sv
// Combinational opcode to immediate-format mapping, shareable between cores.
module multicycle_imm_decode
   import riscv_ctrl_pkg::*;
(
   input  logic [6:0] op_i,
   output logic [2:0] imm_src_o
);

   always_comb begin
      imm_src_o = IMM_I;
      case (op_i)
         OP_LOAD, OP_OPIMM, OP_JALR: imm_src_o = IMM_I;
         OP_STORE:                   imm_src_o = IMM_S;
         OP_BRANCH:                  imm_src_o = IMM_B;
         OP_JAL:                     imm_src_o = IMM_J;
         OP_AUIPC, OP_LUI:           imm_src_o = IMM_U;
         default:                    imm_src_o = 3'b000;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode,
// memory access, ALU work and writeback over a shared memory port and ALU.
module multicycle_controller
   import riscv_ctrl_pkg::*;
#(
   parameter bit RESET_TRAP_CLEAR = 1'b1
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] op,
   input  logic       mem_ready,
   input  logic       trap_ack,
   output logic       PCUpdate,
   output logic       Branch,
   output logic       AdrSrc,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [2:0] ImmSrc,
   output logic       InstrDone,
   output logic       Illegal
);

   state_t state_q, state_d;
   ctrl_t  outs_q;

   function automatic ctrl_t moore_outs(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch      = 1'b1;
            c.alu_src_a  = SRCA_PC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALURES;
         end
         S_DECODE, S_AUIPC: begin
            c.alu_src_a = SRCA_OLDPC;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMADR, S_JALR: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_ADD;
         end
         S_MEMREAD: begin
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
         end
         S_MEMWB: begin
            c.result_src = RES_RDATA;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src    = 1'b1;
            c.result_src = RES_ALUOUT;
            c.mem_write  = 1'b1;
         end
         S_EXECUTER: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_RD2;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_EXECUTEI: begin
            c.alu_src_a = SRCA_RD1;
            c.alu_src_b = SRCB_IMM;
            c.alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = RES_ALUOUT;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a  = SRCA_RD1;
            c.alu_src_b  = SRCB_RD2;
            c.alu_op     = ALUOP_BRANCH;
            c.result_src = RES_ALUOUT;
            c.branch     = 1'b1;
            c.instr_done = 1'b1;
         end
         S_JAL: begin
            // ALUOut already holds the target; the ALU forms OldPC+4 for the link.
            c.alu_src_a  = SRCA_OLDPC;
            c.alu_src_b  = SRCB_FOUR;
            c.alu_op     = ALUOP_ADD;
            c.result_src = RES_ALUOUT;
            c.pc_update  = 1'b1;
         end
         S_LUI: begin
            c.result_src = RES_IMM;
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_TRAP:  c.illegal = 1'b1;
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: if (mem_ready) state_d = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_OP:             state_d = S_EXECUTER;
               OP_OPIMM:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               OP_JALR:           state_d = S_JALR;
               OP_LUI:            state_d = S_LUI;
               OP_AUIPC:          state_d = S_AUIPC;
               default:           state_d = S_TRAP;
            endcase
         end
         S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
         S_EXECUTER: state_d = S_ALUWB;
         S_EXECUTEI: state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JALR:     state_d = S_JAL;
         S_JAL:      state_d = S_ALUWB;
         S_LUI:      state_d = S_FETCH;
         S_AUIPC:    state_d = S_ALUWB;
         S_TRAP:     if (!RESET_TRAP_CLEAR && trap_ack) state_d = S_FETCH;
         default:    state_d = S_TRAP;
      endcase
   end

   // Control word is registered together with the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         outs_q  <= moore_outs(S_FETCH);
      end else begin
         state_q <= state_d;
         outs_q  <= moore_outs(state_d);
      end
   end

   multicycle_imm_decode u_imm_decode (
      .op_i      (op),
      .imm_src_o (ImmSrc)
   );

   // Fetch strobes follow the handshake directly; rst_n keeps them low in reset.
   assign IRWrite   = outs_q.fetch & mem_ready & rst_n;
   assign PCUpdate  = outs_q.pc_update | (outs_q.fetch & mem_ready & rst_n);
   assign InstrDone = outs_q.instr_done | (outs_q.mem_write & mem_ready);
   assign Branch    = outs_q.branch;
   assign AdrSrc    = outs_q.adr_src;
   assign MemWrite  = outs_q.mem_write;
   assign RegWrite  = outs_q.reg_write;
   assign ResultSrc = outs_q.result_src;
   assign ALUSrcA   = outs_q.alu_src_a;
   assign ALUSrcB   = outs_q.alu_src_b;
   assign ALUOp     = outs_q.alu_op;
   assign Illegal   = outs_q.illegal;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: two instances (trap cleared only
// by reset, and trap cleared by trap_ack) driven by shared instruction streams.
module tb_multicycle_controller;

   typedef enum int {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_MEMWRITE, T_EXECR,
      T_EXECI, T_ALUWB, T_BRANCH, T_JALR, T_JAL, T_LUI, T_AUIPC, T_TRAP, T_RESET
   } tst_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] op = 7'b0110011;
   logic       mem_ready = 1'b0;
   logic       trap_ack = 1'b0;

   logic       pcu_a, br_a, adr_a, irw_a, mw_a, rw_a, done_a, ill_a;
   logic [1:0] res_a, sa_a, sb_a, aop_a;
   logic [2:0] imm_a;
   logic       pcu_b, br_b, adr_b, irw_b, mw_b, rw_b, done_b, ill_b;
   logic [1:0] res_b, sa_b, sb_b, aop_b;
   logic [2:0] imm_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   logic [18:0] exp_q[$];

   always #5 clk = ~clk;

   multicycle_controller #(.RESET_TRAP_CLEAR(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .trap_ack(trap_ack),
      .PCUpdate(pcu_a), .Branch(br_a), .AdrSrc(adr_a), .IRWrite(irw_a),
      .MemWrite(mw_a), .RegWrite(rw_a), .ResultSrc(res_a), .ALUSrcA(sa_a),
      .ALUSrcB(sb_a), .ALUOp(aop_a), .ImmSrc(imm_a), .InstrDone(done_a),
      .Illegal(ill_a)
   );

   multicycle_controller #(.RESET_TRAP_CLEAR(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready), .trap_ack(trap_ack),
      .PCUpdate(pcu_b), .Branch(br_b), .AdrSrc(adr_b), .IRWrite(irw_b),
      .MemWrite(mw_b), .RegWrite(rw_b), .ResultSrc(res_b), .ALUSrcA(sa_b),
      .ALUSrcB(sb_b), .ALUOp(aop_b), .ImmSrc(imm_b), .InstrDone(done_b),
      .Illegal(ill_b)
   );

   // {PCUpdate,Branch,AdrSrc,IRWrite,MemWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,InstrDone,Illegal}
   wire [18:0] got_a = {pcu_a, br_a, adr_a, irw_a, mw_a, rw_a, res_a, sa_a, sb_a,
                        aop_a, imm_a, done_a, ill_a};
   wire [18:0] got_b = {pcu_b, br_b, adr_b, irw_b, mw_b, rw_b, res_b, sa_b, sb_b,
                        aop_b, imm_b, done_b, ill_b};

   function automatic logic [2:0] exp_imm(input logic [6:0] o);
      case (o)
         7'b0000011, 7'b0010011, 7'b1100111: return 3'b000;
         7'b0100011:                         return 3'b001;
         7'b1100011:                         return 3'b010;
         7'b1101111:                         return 3'b011;
         7'b0010111, 7'b0110111:             return 3'b100;
         default:                            return 3'b000;
      endcase
   endfunction

   function automatic logic [18:0] exp_outs(input tst_t st, input logic [6:0] o,
                                            input logic mr);
      logic pcu, br, adr, irw, mw, rw, done, ill;
      logic [1:0] res, sa, sb, aop;
      pcu = 0; br = 0; adr = 0; irw = 0; mw = 0; rw = 0; done = 0; ill = 0;
      res = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00;
      case (st)
         T_FETCH:    begin pcu = mr; irw = mr; sb = 2'b10; res = 2'b10; end
         T_RESET:    begin sb = 2'b10; res = 2'b10; end
         T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
         T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
         T_MEMREAD:  adr = 1;
         T_MEMWB:    begin res = 2'b01; rw = 1; done = 1; end
         T_MEMWRITE: begin adr = 1; mw = 1; done = mr; end
         T_EXECR:    begin sa = 2'b10; aop = 2'b10; end
         T_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
         T_ALUWB:    begin rw = 1; done = 1; end
         T_BRANCH:   begin sa = 2'b10; aop = 2'b01; br = 1; done = 1; end
         T_JALR:     begin sa = 2'b10; sb = 2'b01; end
         T_JAL:      begin sa = 2'b01; sb = 2'b10; pcu = 1; end
         T_LUI:      begin res = 2'b11; rw = 1; done = 1; end
         T_AUIPC:    begin sa = 2'b01; sb = 2'b01; end
         default:    ill = 1;
      endcase
      return {pcu, br, adr, irw, mw, rw, res, sa, sb, aop, exp_imm(o), done, ill};
   endfunction

   task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic step(input tst_t sta, input tst_t stb, input logic mr, input logic rn);
      logic [18:0] e;
      mem_ready = mr;
      rst_n = rn;
      exp_q.push_back(exp_outs(sta, op, mr));
      exp_q.push_back(exp_outs(stb, op, mr));
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq($sformatf("A_%s_c%0d", sta.name(), cyc), got_a, e);
      e = exp_q.pop_front();
      check_eq($sformatf("B_%s_c%0d", stb.name(), cyc), got_b, e);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic s(input tst_t st, input logic mr);
      step(st, st, mr, 1'b1);
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   initial begin
      @(posedge clk);
      #1;
      step(T_RESET, T_RESET, 1'b1, 1'b0);

      op = 7'b0110011;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_EXECR, rnd()); s(T_ALUWB, rnd());

      op = 7'b0000011;
      s(T_FETCH, 0); s(T_FETCH, 0); s(T_FETCH, 1); s(T_DECODE, rnd());
      s(T_MEMADR, rnd()); s(T_MEMREAD, 0); s(T_MEMREAD, 1); s(T_MEMWB, rnd());

      op = 7'b0100011;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_MEMADR, rnd());
      s(T_MEMWRITE, 0); s(T_MEMWRITE, 0); s(T_MEMWRITE, 0); s(T_MEMWRITE, 1);

      op = 7'b1100111;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_JALR, rnd()); s(T_JAL, rnd()); s(T_ALUWB, rnd());

      op = 7'b0010011;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_EXECI, rnd()); s(T_ALUWB, rnd());

      op = 7'b1101111;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_JAL, rnd()); s(T_ALUWB, rnd());

      op = 7'b1100011;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_BRANCH, rnd());

      op = 7'b0110111;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_LUI, rnd());

      op = 7'b0010111;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_AUIPC, rnd()); s(T_ALUWB, rnd());

      // Reset lands in the middle of a store; MemWrite must drop at once.
      op = 7'b0100011;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_MEMADR, rnd());
      s(T_MEMWRITE, 0); s(T_MEMWRITE, 0);
      step(T_RESET, T_RESET, 1'b1, 1'b0);
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_MEMADR, rnd()); s(T_MEMWRITE, 1);

      op = 7'b1111111;
      s(T_FETCH, 1); s(T_DECODE, rnd());
      for (int i = 0; i < 10; i++) s(T_TRAP, rnd());
      trap_ack = 1'b1;
      step(T_TRAP, T_TRAP, 1'b0, 1'b1);
      trap_ack = 1'b0;
      step(T_TRAP, T_FETCH, 1'b0, 1'b1);
      step(T_TRAP, T_FETCH, 1'b0, 1'b1);
      step(T_RESET, T_RESET, 1'b0, 1'b0);

      op = 7'b0110011;
      s(T_FETCH, 1); s(T_DECODE, rnd()); s(T_EXECR, rnd()); s(T_ALUWB, rnd());
      s(T_FETCH, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Main control FSM for the multicycle RV32I core variant, where instruction fetch, data access and ALU work share one memory port and one ALU over several cycles. It takes the opcode from the instruction register and a memory-ready handshake. Each cycle it drives the datapath select, enable and write-strobe signals. The ALU decoder and the branch-condition logic stay external and consume ALUOp and Branch.

Parameters:
RESET_TRAP_CLEAR, 1, if 1 only reset leaves TRAP; if 0 TRAP also exits to FETCH when trap_ack=1

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  7  opcode field of instruction register
mem_ready  in  1  memory completes current access this cycle
trap_ack  in  1  trap acknowledge, used only when RESET_TRAP_CLEAR=0
PCUpdate  out  1  unconditional PC write
Branch  out  1  conditional PC write, qualified externally
AdrSrc  out  1  memory address: 0 PC, 1 ALUOut
IRWrite  out  1  latch fetched instruction and OldPC
MemWrite  out  1  data store strobe
RegWrite  out  1  register-file write
ResultSrc  out  2  00 ALUOut, 01 read data, 10 ALU result, 11 ImmExt
ALUSrcA  out  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  out  2  00 RD2, 01 ImmExt, 10 constant 4
ALUOp  out  2  00 add, 01 branch compare, 10 funct-decoded
ImmSrc  out  3  000 I, 001 S, 010 B, 011 J, 100 U
InstrDone  out  1  one-cycle pulse on the last state of each instruction
Illegal  out  1  high while in TRAP

Behaviour:
- Reset (async, rst_n=0): state=FETCH. All strobes (PCUpdate, Branch, IRWrite, MemWrite, RegWrite, InstrDone, Illegal) are 0. Selects take their FETCH values.
- Outputs are a Moore function of state. Exceptions: IRWrite and PCUpdate in FETCH are ANDed with mem_ready, and ImmSrc is decoded combinationally from op in every state.
- ImmSrc by opcode: 0000011/0010011/1100111 give I; 0100011 gives S; 1100011 gives B; 1101111 gives J; 0010111/0110111 give U; all others give 000.
- Any select not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. Stays while mem_ready=0. When mem_ready=1: IRWrite=1 and PCUpdate=1 (PC<=PC+4), then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, so ALUOut receives OldPC+imm.
  - 0000011 and 0100011 go to MEMADR.
  - 0110011 goes to EXECUTER; 0010011 goes to EXECUTEI.
  - 1100011 goes to BRANCH; 1101111 goes to JAL; 1100111 goes to JALR.
  - 0110111 goes to LUI; 0010111 goes to AUIPC.
  - Any other opcode goes to TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. op[5]=0 goes to MEMREAD; op[5]=1 goes to MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Waits on mem_ready, then goes to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, InstrDone=1, then FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 is held every cycle until mem_ready=1. On that cycle InstrDone=1, then FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, InstrDone=1, then FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, InstrDone=1, then FETCH.
- JALR: ALUSrcA=10, ALUSrcB=01, ALUOp=00 (ALUOut<=rs1+imm), then JAL.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1 (PC<=ALUOut target), then ALUWB, which writes OldPC+4.
- LUI: ResultSrc=11, RegWrite=1, InstrDone=1, then FETCH.
- AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00, then ALUWB.
- TRAP: Illegal=1 and all strobes 0. Exit rule: if RESET_TRAP_CLEAR=1, only reset leaves TRAP. If RESET_TRAP_CLEAR=0, trap_ack=1 goes to FETCH.
- Unreachable state encodings go to TRAP.
- Reset asserted mid-access (e.g. in MEMWRITE) drops MemWrite asynchronously. No partial instruction resumes.
- Minimum latency with zero wait states, in cycles:
  - R/I-ALU, AUIPC: 4
  - lw: 5
  - sw: 4
  - branch, LUI: 3
  - jal: 4
  - jalr: 5
- Each wait state adds 1 cycle, in FETCH, MEMREAD or MEMWRITE only.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - the opcode localparams (OP_LOAD, OP_OPIMM, OP_AUIPC, OP_STORE, OP_OP, OP_LUI, OP_BRANCH, OP_JALR, OP_JAL);
  - the state_t enum;
  - the encodings of ImmSrc, ResultSrc, ALUSrcA, ALUSrcB and ALUOp.
- One sub-module, multicycle_imm_decode, is the combinational op→ImmSrc mapping, shareable with other cores. The FSM stays in one module.

Test Plan:
- rst_n low mid-run, then released with mem_ready=1 → state FETCH, all strobes 0, PCUpdate and IRWrite high on the first cycle.
- op=0110011, mem_ready=1 → FETCH, DECODE, EXECUTER, ALUWB. RegWrite and InstrDone high only in cycle 4. Next cycle is FETCH.
- op=0000011, mem_ready low 2 cycles in FETCH and 1 cycle in MEMREAD → 8 cycles total. AdrSrc=1 only in MEMREAD. RegWrite with ResultSrc=01 in the last cycle.
- op=0100011, mem_ready low 3 cycles in MEMWRITE → MemWrite high exactly 4 consecutive cycles. RegWrite never high.
- op=1100111 → states DECODE, JALR, JAL, ALUWB. PCUpdate high in JAL with ResultSrc=00, then RegWrite high. ImmSrc=000 throughout.
- op=1111111 → TRAP with Illegal=1, held for 10 cycles with no strobes. With RESET_TRAP_CLEAR=0, trap_ack=1 returns to FETCH.
